// File: rtl/vertex_clip_transform.sv
// Applies a 4x4 fixed-point projection matrix to view-space vertices (x,y,z,1),
// using one shared multiplier-accumulator that retires one product per cycle.
module vertex_clip_transform #(
  parameter int WI = 8,
  parameter int WF = 8,
  localparam int W = WI + WF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0][W-1:0]   matrix,
  input  logic                 matrix_load,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         vx,
  input  logic [W-1:0]         vy,
  input  logic [W-1:0]         vz,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         cx,
  output logic [W-1:0]         cy,
  output logic [W-1:0]         cz,
  output logic [W-1:0]         cw,
  output logic                 overflow
);

  localparam int AW = 2 * W + 2;
  localparam logic signed [W-1:0]  ONE     = {{(WI-1){1'b0}}, 1'b1, {WF{1'b0}}};
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t                 state_q, state_d;
  logic [3:0]             idx_q;
  logic [15:0][W-1:0]     mat_q;
  logic signed [W-1:0]    vx_p0, vy_p0, vz_p0;
  logic signed [AW-1:0]   acc_p1;
  logic [W-1:0]           c_q [4];
  logic                   ovf_q;

  logic                   accept;
  logic                   row_done;
  logic signed [W-1:0]    m_sel, v_sel;
  logic signed [2*W-1:0]  prod;
  logic signed [AW-1:0]   sum, rnd;

  function automatic logic signed [AW-1:0] round_half_up(input logic signed [AW-1:0] a);
    logic signed [AW-1:0] half;
    half = '0;
    half[WF-1] = 1'b1;
    return (a + half) >>> WF;
  endfunction

  function automatic logic is_clamped(input logic signed [AW-1:0] r);
    return (r > SAT_MAX) || (r < SAT_MIN);
  endfunction

  function automatic logic [W-1:0] saturate(input logic signed [AW-1:0] r);
    if (r > SAT_MAX)      return SAT_MAX[W-1:0];
    else if (r < SAT_MIN) return SAT_MIN[W-1:0];
    else                  return r[W-1:0];
  endfunction

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_ready && in_valid;
  assign row_done  = (state_q == MAC) && (idx_q[1:0] == 2'b11);

  // Stage p0: operand select from the captured vertex and matrix register
  assign m_sel = $signed(mat_q[idx_q]);

  always_comb begin
    v_sel = ONE;
    case (idx_q[1:0])
      2'd0:    v_sel = vx_p0;
      2'd1:    v_sel = vy_p0;
      2'd2:    v_sel = vz_p0;
      default: v_sel = ONE;
    endcase
  end

  // Stage p1: full-precision product folded into the row accumulator
  assign prod = (2*W)'(m_sel) * (2*W)'(v_sel);
  assign sum  = acc_p1 + AW'(prod);
  assign rnd  = round_half_up(sum);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = MAC;
      MAC:     if (idx_q == 4'd15) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mat_q   <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < 4; i++) c_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (in_ready && matrix_load) mat_q <= matrix;
      if (accept) begin
        idx_q <= '0;
        ovf_q <= 1'b0;
      end else if (state_q == MAC) begin
        idx_q <= idx_q + 4'd1;
      end
      if (row_done) begin
        c_q[idx_q[3:2]] <= saturate(rnd);
        if (is_clamped(rnd)) ovf_q <= 1'b1;
      end
    end
  end

  // Datapath registers carry no reset; they are always rewritten on accept
  always_ff @(posedge clk) begin
    if (accept) begin
      vx_p0  <= vx;
      vy_p0  <= vy;
      vz_p0  <= vz;
      acc_p1 <= '0;
    end else if (state_q == MAC) begin
      acc_p1 <= row_done ? '0 : sum;
    end
  end

  assign cx       = c_q[0];
  assign cy       = c_q[1];
  assign cz       = c_q[2];
  assign cw       = c_q[3];
  assign overflow = ovf_q;

endmodule

// File: tb/tb_vertex_clip_transform.sv
// Bench for vertex_clip_transform: directed literal cases plus randomized traffic
// checked every cycle against a plain-arithmetic matrix-times-vertex model.
module tb_vertex_clip_transform;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [15:0][15:0]  matrix;
  logic               matrix_load;
  logic               in_valid;
  logic               in_ready;
  logic [15:0]        vx, vy, vz;
  logic               out_valid;
  logic               out_ready;
  logic [15:0]        cx, cy, cz, cw;
  logic               overflow;

  vertex_clip_transform #(.WI(8), .WF(8)) dut (
    .clk(clk), .rst(rst), .matrix(matrix), .matrix_load(matrix_load),
    .in_valid(in_valid), .in_ready(in_ready), .vx(vx), .vy(vy), .vz(vz),
    .out_valid(out_valid), .out_ready(out_ready),
    .cx(cx), .cy(cy), .cz(cz), .cw(cw), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][15:0] c;
    logic             ovf;
  } res_t;

  int                n_vec = 0;
  int                n_bad = 0;
  int                cyc = 0;
  res_t              exp_q[$];
  int                cyc_q[$];
  logic [15:0][15:0] mdl_mat = '0;
  logic [3:0][15:0]  last_c = '0;
  logic              seen = 1'b0;
  logic [3:0][15:0]  dut_c;

  assign dut_c = {cw, cz, cy, cx};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Clip = M * (x,y,z,1) in real fixed-point arithmetic, rounded half up, clamped.
  function automatic res_t model(input logic [15:0][15:0] m, input logic [15:0] x, y, z);
    res_t   r;
    longint v[4];
    longint s;
    r = '0;
    v[0] = longint'($signed(x));
    v[1] = longint'($signed(y));
    v[2] = longint'($signed(z));
    v[3] = 256;
    for (int i = 0; i < 4; i++) begin
      s = 0;
      for (int j = 0; j < 4; j++) s += longint'($signed(m[4*i+j])) * v[j];
      s = (s + 128) >>> 8;
      if (s > 32767) begin
        s = 32767;
        r.ovf = 1'b1;
      end else if (s < -32768) begin
        s = -32768;
        r.ovf = 1'b1;
      end
      r.c[i] = 16'(s);
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      cyc_q.delete();
      seen    = 1'b0;
      last_c  = '0;
      mdl_mat = '0;
    end else begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", 32'(out_valid), 32'd0);
      end else begin
        if (!seen) begin
          chk("latency", 32'(out_valid), 32'(cyc == cyc_q[0]));
          if (out_valid) seen = 1'b1;
        end
        if (out_valid) begin
          for (int r = 0; r < 4; r++)
            chk($sformatf("c%0d", r), 32'(dut_c[r]), 32'(exp_q[0].c[r]));
          chk("overflow", 32'(overflow), 32'(exp_q[0].ovf));
          chk("in_ready_done", 32'(in_ready), 32'd0);
          if (out_ready) begin
            last_c = exp_q[0].c;
            void'(exp_q.pop_front());
            void'(cyc_q.pop_front());
            seen = 1'b0;
          end
        end
      end
      if (in_ready) begin
        for (int r = 0; r < 4; r++)
          chk($sformatf("idle_hold_c%0d", r), 32'(dut_c[r]), 32'(last_c[r]));
        if (matrix_load) mdl_mat = matrix;
        if (in_valid) begin
          exp_q.push_back(model(mdl_mat, vx, vy, vz));
          cyc_q.push_back(cyc + 17);
        end
      end
    end
  end

  function automatic logic [15:0][15:0] ident(input logic [15:0] d);
    logic [15:0][15:0] m;
    m = '0;
    m[0] = d; m[5] = d; m[10] = d; m[15] = d;
    return m;
  endfunction

  function automatic logic [15:0] rnd_word();
    if ($urandom_range(0, 3) == 0) return 16'($urandom);
    return 16'(int'($urandom_range(0, 1023)) - 512);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string nm, input logic [15:0][15:0] m,
                          input logic [15:0] x, y, z,
                          input logic [63:0] exp_c, input logic eovf);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin step(); n++; end
    chk({nm, "_rdy"}, 32'(in_ready), 32'd1);
    matrix = m; matrix_load = 1'b1;
    vx = x; vy = y; vz = z; in_valid = 1'b1; out_ready = 1'b1;
    step();
    matrix_load = 1'b0; in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin step(); n++; end
    chk({nm, "_lat"}, 32'(n), 32'd16);
    chk({nm, "_cx"}, 32'(cx), 32'(exp_c[15:0]));
    chk({nm, "_cy"}, 32'(cy), 32'(exp_c[31:16]));
    chk({nm, "_cz"}, 32'(cz), 32'(exp_c[47:32]));
    chk({nm, "_cw"}, 32'(cw), 32'(exp_c[63:48]));
    chk({nm, "_ovf"}, 32'(overflow), 32'(eovf));
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0][15:0] m;
    res_t              pin;
    int                n, n_acc, guard;
    logic              take;

    matrix = '0; matrix_load = 1'b0; in_valid = 1'b0;
    vx = '0; vy = '0; vz = '0; out_ready = 1'b1;

    // reset state
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_cx", 32'(cx), 32'd0);
    chk("rst_cw", 32'(cw), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // pin the reference model against hand-computed values
    m = '0; m[0] = 16'h0200; m[5] = 16'h0100; m[10] = 16'h0180; m[11] = 16'hFF00; m[14] = 16'h0100;
    pin = model(m, 16'h0100, 16'h0100, 16'hFE00);
    chk("model_t2", 32'(pin.c[2]), 32'h0000_FC00);
    chk("model_t2w", 32'(pin.c[3]), 32'h0000_FE00);
    m = '0; m[0] = 16'h0080;
    pin = model(m, 16'hFFFF, 16'h0, 16'h0);
    chk("model_round", 32'(pin.c[0]), 32'd0);

    directed("ident", ident(16'h0100), 16'h0200, 16'hFD00, 16'h0080,
             64'h0100_0080_FD00_0200, 1'b0);
    m = '0; m[0] = 16'h0200; m[5] = 16'h0100; m[10] = 16'h0180; m[11] = 16'hFF00; m[14] = 16'h0100;
    directed("mixed", m, 16'h0100, 16'h0100, 16'hFE00, 64'hFE00_FC00_0100_0200, 1'b0);
    m = '0; m[0] = 16'h7F00;
    directed("sat_hi", m, 16'h0200, 16'h0, 16'h0, 64'h0000_0000_0000_7FFF, 1'b1);
    directed("sat_lo", m, 16'hFE00, 16'h0, 16'h0, 64'h0000_0000_0000_8000, 1'b1);
    m = '0; m[0] = 16'h0080;
    directed("rnd_pos", m, 16'h0001, 16'h0, 16'h0, 64'h0000_0000_0000_0001, 1'b0);
    directed("rnd_neg", m, 16'hFFFF, 16'h0, 16'h0, 64'h0, 1'b0);

    // backpressure in DONE, pending vertex, matrix_load during MAC
    matrix = ident(16'h0100); matrix_load = 1'b1;
    vx = 16'h0300; vy = 16'h0100; vz = 16'hFF80; in_valid = 1'b1; out_ready = 1'b0;
    step();
    matrix = ident(16'h0200);
    vx = 16'h0040; vy = 16'h0010; vz = 16'h0020;
    for (int i = 0; i < 5; i++) step();
    matrix_load = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin step(); n++; end
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_cx", 32'(cx), 32'h0300);
      chk("bp_cz", 32'(cz), 32'hFF80);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("bp_idle", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin step(); n++; end
    chk("pend_cx", 32'(cx), 32'h0040);
    chk("pend_cw", 32'(cw), 32'h0100);
    step();

    // reset in the middle of MAC
    matrix = ident(16'h0100); matrix_load = 1'b1;
    vx = 16'h0100; vy = 16'h0200; vz = 16'h0300; in_valid = 1'b1;
    step();
    matrix_load = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 8; i++) step();
    rst = 1'b1;
    #1;
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_cx", 32'(cx), 32'd0);
    chk("mrst_cy", 32'(cy), 32'd0);
    chk("mrst_ovf", 32'(overflow), 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("mrst_rdy", 32'(in_ready), 32'd1);
    directed("after_rst", ident(16'h0100), 16'h0100, 16'hFF00, 16'h0040,
             64'h0100_0040_FF00_0100, 1'b0);

    // randomized traffic
    n_acc = 0; guard = 0; take = 1'b0;
    while (n_acc < 60 && guard < 5000) begin
      if (!(in_valid && !take)) begin
        in_valid = ($urandom_range(0, 2) != 0);
        vx = rnd_word(); vy = rnd_word(); vz = rnd_word();
      end
      matrix_load = ($urandom_range(0, 4) == 0);
      if (matrix_load)
        for (int i = 0; i < 16; i++) matrix[i] = rnd_word();
      out_ready = ($urandom_range(0, 3) != 0);
      take = in_valid && in_ready;
      step();
      if (take) n_acc++;
      guard++;
    end
    chk("rand_accepts", 32'(n_acc), 32'd60);
    in_valid = 1'b0; matrix_load = 1'b0; out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin step(); guard++; end
    chk("drain", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
